// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller states and default sizing.
package mul_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam int STATE_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// Datapath of the shift-and-add multiplier: M, Q, A, C, product registers, adder, shifter, counter.
module shift_add_multiplier_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int COUNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic               shift_en,
    input  logic               ld_product,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] product,
    output logic               status
);
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_a;
    logic               r_c;
    logic [COUNT_W-1:0] r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_q_next;

    // Add M when the multiplier LSB is set, then shift {C,A,Q} right by one in the same cycle.
    assign w_sum    = r_q[0] ? ({r_c, r_a} + {1'b0, r_m}) : {r_c, r_a};
    assign w_a_next = w_sum[WIDTH:1];
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

    assign status  = (r_count == COUNT_W'(WIDTH - 1));
    assign product = r_product;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m       <= '0;
            r_q       <= '0;
            r_a       <= '0;
            r_c       <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else if (ld) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= addend;
            r_c     <= 1'b0;
            r_count <= '0;
        end else if (shift_en) begin
            r_a     <= w_a_next;
            r_q     <= w_q_next;
            r_c     <= 1'b0;
            r_count <= r_count + COUNT_W'(1);
            if (ld_product) begin
                r_product <= {w_a_next, w_q_next};
            end
        end
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier: controller FSM plus datapath.
// Define MUL_ADDEND_EN to add the addend port, giving product = M*Q + addend.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int COUNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef MUL_ADDEND_EN
    input  logic [WIDTH-1:0]   addend,
`endif
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done,
    output logic               status
);
    state_t           r_state;
    logic             r_busy;
    logic             r_done;

    logic             w_ld;
    logic             w_shift_en;
    logic             w_ld_product;
    logic             w_status;
    logic [WIDTH-1:0] w_addend;

`ifdef MUL_ADDEND_EN
    assign w_addend = addend;
`else
    assign w_addend = '0;
`endif

    assign w_ld         = (r_state == LOAD);
    assign w_shift_en   = (r_state == CALC);
    assign w_ld_product = w_shift_en & w_status;

    assign busy   = r_busy;
    assign done   = r_done;
    assign status = w_status;

    // busy and done are registered alongside the state so they change exactly on state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= CALC;
                end
                CALC: begin
                    if (w_status) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    shift_add_multiplier_datapath #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .ld           (w_ld),
        .shift_en     (w_shift_en),
        .ld_product   (w_ld_product),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (w_addend),
        .product      (product),
        .status       (w_status)
    );
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential shift-and-add unsigned multiplier. It is the inverse companion of the restoring divider and sits beside it in the arithmetic block. From quotient and divisor it computes the product one bit per clock. With the multiply-add option compiled in, it adds the remainder back, so that dividend = quotient × divisor + remainder can be checked in hardware. It is split into a controller FSM and a datapath, using the same load, shift and count style as the divider.

## Interface

Parameters:
- WIDTH, default 4: operand width. Must be a power of two and at least 2.
- COUNT_W, default $clog2(WIDTH): iteration counter width.

Ports:
- clk  input  1  rising-edge clock; the only clock domain.
- rst  input  1  asynchronous, active-low reset. rst = 0 resets immediately, independent of clk.
- start  input  1  request to begin; sampled only in IDLE.
- multiplicand  input  WIDTH  M operand (divisor side); captured in LOAD.
- multiplier  input  WIDTH  Q operand (quotient side); captured in LOAD.
- addend  input  WIDTH  remainder to add; captured in LOAD. The port is present only with MUL_ADDEND_EN.
- product  output  2*WIDTH  result register; holds its value until the next completion.
- busy  output  1  high in LOAD and CALC.
- done  output  1  one-cycle pulse, high in DONE.
- status  output  1  count == WIDTH-1; debug and visibility.

## Operation

FSM states: IDLE, LOAD, CALC, DONE.
- **IDLE:** if start = 1, go to LOAD; otherwise stay.
- **LOAD:** load the registers as follows, then go to CALC.
  - M <= multiplicand
  - Q <= multiplier
  - A <= addend, or 0 without the macro
  - C <= 0
  - count <= 0
- **CALC:** one iteration per cycle.
  - If Q[0] = 1: {C,A} = A + M, a (WIDTH+1)-bit sum. Otherwise {C,A} = {0,A}.
  - Then shift right: {C,A,Q} <= {0,C,A,Q} >> 1, with the sum result used in the same cycle.
  - count increments each cycle.
  - When status = 1, perform the final iteration, load product <= {A,Q} (post-shift value), and go to DONE.
- **DONE:** done = 1 for exactly one cycle, then go to IDLE unconditionally.
- start outside IDLE is ignored, including during DONE. There are no queued requests.
- Operand inputs are sampled only in LOAD and may change at any other time.

Arithmetic:
- The result is unsigned: product = multiplicand × multiplier (+ addend).
- The maximum value is (2^W − 1)² + (2^W − 1) = 2^(2W) − 2^W, which always fits in 2W bits, so no overflow is possible.
- C carries the (W+1)-th sum bit into the shift, so no bits are lost.

## Timing

- **Reset (rst = 0):** state = IDLE and every register clears, so product = 0, busy = 0, done = 0, status = 0 and count = 0.
- **Reset mid-operation:** the operation is aborted, state goes to IDLE and product clears to 0. There is no done pulse.
- **Latency:** start is sampled at edge E0. LOAD occupies E0 to E1. CALC iterations execute at edges E2 through E(W+1). done is high in the cycle after E(W+1). For W = 4, done is high 6 cycles after start is sampled.
- **Throughput:** one result per W+3 cycles at best, because DONE returns to IDLE before the next start is sampled.
- **busy:** rises the cycle after start is sampled and falls in the same cycle that done rises.
- **Counter wrap:** count wraps from WIDTH−1 to 0 at the final CALC edge. This wrap is harmless because LOAD reinitialises count.

## Configuration

- **MUL_ADDEND_EN defined:**
  - The addend port exists.
  - A is preloaded with addend in LOAD.
  - product = M×Q + addend.
- **MUL_ADDEND_EN undefined:**
  - There is no addend port.
  - A is preloaded with 0.
  - product = M×Q.
  - Logic is otherwise identical.

## Structure

- **Shared package mul_pkg:**
  - state enum: IDLE, LOAD, CALC, DONE
  - default WIDTH constant
  - state encoding width
- **Sub-module shift_add_multiplier_datapath:** holds the registers M, Q, A, C and product, the adder, the shifter and the counter. It exports status and accepts ld, shift_en and ld_product.
- **Top level shift_add_multiplier:** the controller FSM plus instantiation of the datapath.

## Test plan

- **Basic multiply:** reset, then M = 13, Q = 11, start pulse. Expect done 6 cycles later with product = 0x8F (143). busy is high for exactly 5 cycles.
- **Extremes:** M = 15, Q = 15 gives product = 225 (0xE1). M = 0, Q = 9 gives product = 0. M = 9, Q = 0 gives product = 0.
- **Multiply-add (MUL_ADDEND_EN defined):** M = 7, Q = 2, addend = 1 gives product = 15. M = 15, Q = 15, addend = 15 gives product = 240.
- **Ignored start:** re-pulse start in CALC and in DONE. There must be no extra done pulse, and product must be unchanged until the next accepted start. A new start in IDLE with M = 3, Q = 5 gives 15.
- **Reset mid-operation:** assert rst = 0 two cycles into CALC. Outputs must clear immediately with no done pulse. The next operation, M = 6, Q = 6, must give 36.
- **Sweep with divider check:** an exhaustive 4-bit sweep of M×Q against a reference model. With the macro, feed divider outputs (quotient, divisor, remainder) and compare product with the original dividend.
